fft_result_out: RTL and testbench

FFT_RESULT_OUT -- requirements
Module: fft_result_out

---
 rtl/fft_result_out.sv | 146 ++++++++++++++
 tb/tb_fft_result_out.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_out.sv
// FFT result reorder buffer: captures butterfly-order results, then drains them
// as natural-order bins with I, Q and magnitude-squared under a valid/ready handshake.
module fft_result_out #(
  parameter int N           = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int BIT_REVERSE = 1,
  localparam int ADDR_WIDTH = $clog2(N),
  localparam int W2         = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [W2-1:0]         in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [W2-1:0]         out_mag,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic {LOAD, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [N-1:0]          wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  done_q, done_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic [DATA_WIDTH-1:0] out_q_q, out_q_d;
  logic [W2-1:0]         out_mag_q, out_mag_d;

  logic [W2-1:0]         mem_q [N];
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  in_xfer, advance, fire;
  logic [W2-1:0]         rd_word, ext_i, ext_q, rd_mag;

  assign in_ready = rst_n & (state_q == LOAD);
  assign in_xfer  = in_valid & in_ready;
  assign busy     = (state_q == DRAIN);

  always_comb begin
    wr_idx = in_addr;
    if (BIT_REVERSE != 0)
      for (int b = 0; b < ADDR_WIDTH; b++) wr_idx[b] = in_addr[ADDR_WIDTH-1-b];
  end

  // Entries not written this frame read as zero, so the RAM itself never needs clearing.
  assign rd_word = wr_q[rd_idx_q] ? mem_q[rd_idx_q] : '0;
  assign ext_i   = {{DATA_WIDTH{rd_word[W2-1]}}, rd_word[W2-1:DATA_WIDTH]};
  assign ext_q   = {{DATA_WIDTH{rd_word[DATA_WIDTH-1]}}, rd_word[DATA_WIDTH-1:0]};
  // Modular W2-bit arithmetic is exact here: the largest sum is 2^(W2-1).
  assign rd_mag  = ext_i * ext_i + ext_q * ext_q;

  assign advance = out_valid_q & out_ready;
  assign fire    = (state_q == DRAIN) & ~done_q & (~out_valid_q | advance);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_idx_d    = rd_idx_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_mag_d   = out_mag_q;
    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          wr_d[wr_idx] = 1'b1;
          if (in_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fire) begin
          out_valid_d = 1'b1;
          out_index_d = rd_idx_q;
          out_i_d     = rd_word[W2-1:DATA_WIDTH];
          out_q_d     = rd_word[DATA_WIDTH-1:0];
          out_mag_d   = rd_mag;
          out_last_d  = (rd_idx_q == ADDR_WIDTH'(N - 1));
          rd_idx_d    = rd_idx_q + 1'b1;
          if (rd_idx_q == ADDR_WIDTH'(N - 1)) done_d = 1'b1;
        end else if (advance) begin
          out_valid_d = 1'b0;
        end
        if (advance & out_last_q) begin
          state_d     = LOAD;
          wr_d        = '0;
          rd_idx_d    = '0;
          done_d      = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wr_q        <= '0;
      rd_idx_q    <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_mag_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_idx_q    <= rd_idx_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_mag_q   <= out_mag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) mem_q[wr_idx] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_fft_result_out.sv
// Directed bench for fft_result_out with N=64, DATA_WIDTH=8, bit reversal on.
module tb_fft_result_out;
  localparam int N = 64;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [5:0]  in_addr;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [5:0]  out_index;
  logic [7:0]  out_i, out_q;
  logic [15:0] out_mag;

  int checks = 0, failures = 0;
  int exp_i [N];
  int exp_q [N];

  fft_result_out dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_i(out_i), .out_q(out_q), .out_mag(out_mag), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev6(input int a);
    int r = 0;
    for (int b = 0; b < 6; b++) r = r * 2 + ((a >> b) & 1);
    return r;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < N; b++) begin exp_i[b] = 0; exp_q[b] = 0; end
  endtask

  task automatic model_write(input int addr, input int i, input int q);
    exp_i[rev6(addr)] = i;
    exp_q[rev6(addr)] = q;
  endtask

  task automatic send_word(input int addr, input int i, input int q, input logic last);
    logic [7:0] bi, bq;
    int wait_cyc = 0;
    bi = i[7:0];
    bq = q[7:0];
    in_addr  = addr[5:0];
    in_data  = {bi, bq};
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collects bins until lim have been accepted; mode 0 = ready held high, 1 = LFSR pattern.
  task automatic drain(input int mode, input int lim);
    int nb = 0, cyc = 0, first_c = 0, last_c = 0, mag;
    logic [7:0] lfsr = 8'hA5;
    logic rdy, stalled = 0;
    logic [5:0] h_idx;
    logic [7:0] h_i, h_q;
    logic [15:0] h_mag;
    logic [7:0] ei, eq;
    while (nb < lim && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      rdy = (mode == 0) ? 1'b1 : lfsr[0];
      out_ready = rdy;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_index", out_index, h_idx);
        chk("stall_i", out_i, h_i);
        chk("stall_q", out_q, h_q);
        chk("stall_mag", out_mag, h_mag);
      end
      stalled = 0;
      if (out_valid) begin
        if (rdy) begin
          ei = exp_i[nb][7:0];
          eq = exp_q[nb][7:0];
          mag = exp_i[nb] * exp_i[nb] + exp_q[nb] * exp_q[nb];
          chk("bin_index", out_index, nb);
          chk("bin_i", out_i, ei);
          chk("bin_q", out_q, eq);
          chk("bin_mag", out_mag, mag[15:0]);
          chk("bin_last", out_last, (nb == N - 1));
          chk("busy_drain", busy, 1);
          chk("in_ready_drain", in_ready, 0);
          if (nb == 0) first_c = cyc;
          last_c = cyc;
          nb++;
        end else begin
          stalled = 1;
          h_idx = out_index; h_i = out_i; h_q = out_q; h_mag = out_mag;
        end
      end
    end
    if (nb < lim) chk("drain_timeout", nb, lim);
    if (lim == N) begin
      if (mode == 0) chk("consecutive_bins", last_c - first_c, N - 1);
      @(negedge clk);
      out_ready = 1'b0;
      chk("ready_after_last", in_ready, 1);
      chk("valid_after_last", out_valid, 0);
      chk("busy_after_last", busy, 0);
    end
  endtask

  task automatic fill_frame();
    model_clear();
    for (int k = 0; k < N; k++) begin
      send_word(k, k, -k, k == N - 1);
      model_write(k, k, -k);
    end
  endtask

  initial begin
    int lat;
    rst_n = 0; in_valid = 0; in_last = 0; in_addr = 0; in_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_fields", {out_index, out_i, out_q}, 0);
    chk("rst_mag", out_mag, 0);
    rst_n = 1;
    #1 chk("rel_in_ready", in_ready, 1);

    // Full frame, first-valid latency, ready held high
    fill_frame();
    lat = 1;
    while (!out_valid && lat < 6) begin @(negedge clk); lat++; end
    chk("first_valid_le3", lat <= 3, 1);
    drain(0, N);

    // Same frame with pseudo-random backpressure
    fill_frame();
    drain(1, N);

    // Partial frame: only addr 1 -> bin 32
    model_clear();
    send_word(1, 3, 4, 1);
    model_write(1, 3, 4);
    drain(0, N);

    // Extremes at addr 0
    model_clear();
    send_word(0, -128, -128, 1);
    model_write(0, -128, -128);
    drain(0, N);

    // Reset after bin 10 is delivered
    fill_frame();
    drain(0, 11);
    @(negedge clk);
    rst_n = 0;
    out_ready = 0;
    #1 chk("midrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    model_clear();
    send_word(2, 5, -7, 1);
    model_write(2, 5, -7);
    drain(0, N);

    // Back-to-back: second frame pushed while the first drains
    fill_frame();
    fork
      drain(0, N);
      for (int k = 0; k < N; k++) send_word(k, 63 - k, k, k == N - 1);
    join
    model_clear();
    for (int k = 0; k < N; k++) model_write(k, 63 - k, k);
    drain(0, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
